etc_lane_ctrl: RTL

- Per-lane sequencer for the nonstop ETC barrier datapath.
- Detects an arriving vehicle, waits for its RFID tag, checks blacklist and balance against the lane fee, then issues the debit.
- Drives the barrier datapath's init/up/down/en/dis command inputs so that the barrier opens for exactly one paid vehicle and closes after it passes.
- Also merges the operator open/close override into the en/dis commands, with a safety-first priority.

---
 rtl/etc_pkg.sv | 24 ++
 rtl/etc_lane_ctrl_if.sv | 38 +++
 rtl/etc_lane_timer.sv | 26 ++
 rtl/etc_lane_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared types and defaults for the ETC lane sequencer.
package etc_pkg;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        IDLE      = 3'd1,
        WAIT_TAG  = 3'd2,
        CHECK     = 3'd3,
        OPEN      = 3'd4,
        WAIT_PASS = 3'd5,
        CLOSE     = 3'd6,
        REJECT    = 3'd7
    } state_t;

    localparam int DEF_BAL_W        = 16;
    localparam int DEF_FEE_W        = 12;
    localparam int DEF_TAG_TIMEOUT  = 200;
    localparam int DEF_PASS_TIMEOUT = 1000;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/etc_lane_ctrl_if.sv
// Lane-side signal bundle: vehicle/tag/operator inputs and datapath command outputs.
interface etc_lane_ctrl_if
    import etc_pkg::*;
#(
    parameter int BAL_W = DEF_BAL_W,
    parameter int FEE_W = DEF_FEE_W
);
    logic             car_detect;
    logic             tag_valid;
    logic [BAL_W-1:0] tag_balance;
    logic             tag_blacklisted;
    logic [FEE_W-1:0] fee;
    logic             car_passed;
    logic             op_open;
    logic             op_close;
    logic             init;
    logic             up;
    logic             down;
    logic             en;
    logic             dis;
    logic             debit_valid;
    logic [FEE_W-1:0] debit_amount;
    logic             alarm;
    logic             busy;

    modport master (
        output car_detect, tag_valid, tag_balance, tag_blacklisted, fee,
               car_passed, op_open, op_close,
        input  init, up, down, en, dis, debit_valid, debit_amount, alarm, busy
    );

    modport slave (
        input  car_detect, tag_valid, tag_balance, tag_blacklisted, fee,
               car_passed, op_open, op_close,
        output init, up, down, en, dis, debit_valid, debit_amount, alarm, busy
    );

endinterface

// File: rtl/etc_lane_timer.sv
// Clear/enable saturating cycle counter with a terminal-count compare.
module etc_lane_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         hit
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/etc_lane_ctrl.sv
// Per-lane ETC sequencer: vehicle detect, tag check, debit, barrier open/close,
// with operator override merged in (close always wins).
module etc_lane_ctrl
    import etc_pkg::*;
#(
    parameter int BAL_W        = DEF_BAL_W,
    parameter int FEE_W        = DEF_FEE_W,
    parameter int TAG_TIMEOUT  = DEF_TAG_TIMEOUT,
    parameter int PASS_TIMEOUT = DEF_PASS_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset_n,
    etc_lane_ctrl_if.slave  lane
);

    localparam int TMR_W = $clog2(max_of(TAG_TIMEOUT, PASS_TIMEOUT) + 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] count;
    logic [TMR_W-1:0] limit;
    logic             hit;
    logic             tmr_clr;
    logic             tmr_en;
    logic [BAL_W-1:0] bal_held;
    logic             bl_held;
    logic             pass_ok;
    logic             pass_timeout;

    logic             init_d;
    logic             up_d;
    logic             down_d;
    logic             en_d;
    logic             dis_d;
    logic             debit_d;
    logic [FEE_W-1:0] amount_d;
    logic             alarm_d;
    logic             busy_d;

    // One counter serves both waits; the limit follows whichever wait is active.
    assign limit   = (state == WAIT_TAG) ? TMR_W'(TAG_TIMEOUT - 1) : TMR_W'(PASS_TIMEOUT - 1);
    assign tmr_en  = (state == WAIT_TAG) || (state == WAIT_PASS);
    assign tmr_clr = (state_nxt != state) && ((state_nxt == WAIT_TAG) || (state_nxt == WAIT_PASS));

    etc_lane_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (limit),
        .count   (count),
        .hit     (hit)
    );

    always_ff @(posedge clk) begin
        if ((state == WAIT_TAG) && lane.tag_valid) begin
            bal_held <= lane.tag_balance;
            bl_held  <= lane.tag_blacklisted;
        end
    end

    assign pass_ok      = !bl_held && (bal_held >= BAL_W'(lane.fee));
    assign pass_timeout = (state == WAIT_PASS) && hit && !lane.car_passed;

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:      state_nxt = IDLE;
            IDLE:      if (lane.car_detect) state_nxt = WAIT_TAG;
            WAIT_TAG: begin
                if (lane.tag_valid)       state_nxt = CHECK;
                else if (!lane.car_detect) state_nxt = IDLE;
                else if (hit)             state_nxt = REJECT;
            end
            CHECK:     state_nxt = pass_ok ? OPEN : REJECT;
            OPEN:      state_nxt = WAIT_PASS;
            WAIT_PASS: if (lane.car_passed || hit) state_nxt = CLOSE;
            CLOSE:     state_nxt = IDLE;
            REJECT:    if (!lane.car_detect) state_nxt = IDLE;
            default:   state_nxt = INIT;
        endcase
    end

    // Any close (operator or automatic) masks an open issued in the same cycle.
    always_comb begin
        init_d   = (state == INIT);
        debit_d  = (state_nxt == OPEN);
        amount_d = debit_d ? lane.fee : '0;
        up_d     = debit_d && !lane.op_close;
        down_d   = (state_nxt == CLOSE);
        dis_d    = lane.op_close;
        en_d     = lane.op_open && !lane.op_close && !down_d;
        alarm_d  = (state_nxt == REJECT) || pass_timeout;
        busy_d   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= INIT;
            lane.init         <= 1'b0;
            lane.up           <= 1'b0;
            lane.down         <= 1'b0;
            lane.en           <= 1'b0;
            lane.dis          <= 1'b0;
            lane.debit_valid  <= 1'b0;
            lane.debit_amount <= '0;
            lane.alarm        <= 1'b0;
            lane.busy         <= 1'b0;
        end else begin
            state             <= state_nxt;
            lane.init         <= init_d;
            lane.up           <= up_d;
            lane.down         <= down_d;
            lane.en           <= en_d;
            lane.dis          <= dis_d;
            lane.debit_valid  <= debit_d;
            lane.debit_amount <= amount_d;
            lane.alarm        <= alarm_d;
            lane.busy         <= busy_d;
        end
    end

endmodule
